branch_exec_unit: RTL and testbench

BRANCH_EXEC_UNIT -- requirements
Module: branch_exec_unit

---
 rtl/branch_exec_unit_pkg.sv | 28 ++
 rtl/branch_exec_unit_br_compare.sv | 26 ++
 rtl/branch_exec_unit.sv | 172 +++++++++++++++++
 tb/tb_branch_exec_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_exec_unit_pkg.sv
// Shared definitions for the branch execution unit: source-tag sentinel,
// branch funct3 encodings and the issue packet held in the first stage.
package branch_exec_unit_pkg;

  // Operand tag meaning "no register source" (JAL instead of JALR)
  localparam logic [7:0] NO_SRC_TAG = 8'hFF;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Issue packet captured in S1; only fields needed after capture are kept
  typedef struct packed {
    logic        jump;
    logic        pred_taken;
    logic [7:0]  phy;
    logic [31:0] inst_num;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [7:0]  op1;
    logic [7:0]  op2;
  } issue_pkt_t;

endpackage

// File: rtl/branch_exec_unit_br_compare.sv
// br_compare: combinational branch condition evaluator keyed on funct3.
// Encodings 010/011 are not branches and always evaluate to not taken.
module br_compare
  import branch_exec_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        taken
);

  // Evaluate the comparison selected by funct3
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (src1 == src2);
      F3_BNE:  taken = (src1 != src2);
      F3_BLT:  taken = ($signed(src1) <  $signed(src2));
      F3_BGE:  taken = ($signed(src1) >= $signed(src2));
      F3_BLTU: taken = (src1 <  src2);
      F3_BGEU: taken = (src1 >= src2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_exec_unit.sv
// branch_exec_unit: two-stage branch/jump resolution pipeline.
// S1 captures the issue and reads the register file; S2 registers the
// resolved outcome. A mispredict kills the younger S1 entry; exception or
// mret kills everything in flight.
// Optional: define BR_STATS_EN to add saturating br_count/mispredict_count.
module branch_exec_unit
  import branch_exec_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        RS_BR_Branch,
  input  logic        RS_BR_Jump,
  input  logic        RS_BR_Hit,
  input  logic        RS_BR_taken,
  input  logic [7:0]  RS_BR_Phy,
  input  logic [31:0] RS_BR_inst_num,
  input  logic [2:0]  RS_BR_funct3,
  input  logic [31:0] immediate_BR,
  input  logic [31:0] PC_BR,
  input  logic [7:0]  Operand1_BR_phy,
  input  logic [7:0]  Operand2_BR_phy,
  output logic [7:0]  rf_rd_addr1,
  output logic [7:0]  rf_rd_addr2,
  input  logic [31:0] rf_rd_data1,
  input  logic [31:0] rf_rd_data2,
  input  logic        exception_sig,
  input  logic        mret_sig,
  output logic        BR_Done,
  output logic [7:0]  BR_Phy,
  output logic        BR_wr_en,
  output logic [31:0] BR_wr_data,
  output logic [31:0] BR_inst_num,
  output logic        Predict_Result,
  output logic [31:0] Redirect_PC,
  output logic        btb_upd_valid,
  output logic [31:0] btb_upd_PC,
  output logic [31:0] btb_upd_target,
  output logic        btb_upd_taken
`ifdef BR_STATS_EN
  ,
  output logic [31:0] br_count,
  output logic [31:0] mispredict_count
`endif
);

  logic       flush;
  logic       issue_valid;
  issue_pkt_t issue_pkt;
  issue_pkt_t s1_pkt;
  logic       s1_valid;
  logic       s1_resolve;

  logic        cond_taken;
  logic        is_jalr;
  logic        act_taken;
  logic        mispredict;
  logic [31:0] fall_pc;
  logic [31:0] target;
  logic [31:0] redirect;

  assign flush       = exception_sig | mret_sig;
  assign issue_valid = RS_BR_Branch | RS_BR_Jump;

  // Assemble the incoming issue packet; prediction collapses to one bit
  always_comb begin
    issue_pkt            = '0;
    issue_pkt.jump       = RS_BR_Jump;
    issue_pkt.pred_taken = RS_BR_Hit & RS_BR_taken;
    issue_pkt.phy        = RS_BR_Phy;
    issue_pkt.inst_num   = RS_BR_inst_num;
    issue_pkt.funct3     = RS_BR_funct3;
    issue_pkt.imm        = immediate_BR;
    issue_pkt.pc         = PC_BR;
    issue_pkt.op1        = Operand1_BR_phy;
    issue_pkt.op2        = Operand2_BR_phy;
  end

  // S1: capture the issue; a flush drops whatever is arriving this cycle too
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_pkt   <= '0;
    end else if (flush || !issue_valid) begin
      s1_valid <= 1'b0;
      s1_pkt   <= '0;
    end else begin
      s1_valid <= 1'b1;
      s1_pkt   <= issue_pkt;
    end
  end

  assign rf_rd_addr1 = s1_pkt.op1;
  assign rf_rd_addr2 = s1_pkt.op2;

  br_compare u_br_compare (
    .funct3 (s1_pkt.funct3),
    .src1   (rf_rd_data1),
    .src2   (rf_rd_data2),
    .taken  (cond_taken)
  );

  // Resolve target, actual direction and mispredict from S1 and regfile data
  always_comb begin
    fall_pc    = s1_pkt.pc + 32'd4;
    is_jalr    = s1_pkt.jump && (s1_pkt.op1 != NO_SRC_TAG);
    target     = is_jalr ? ((rf_rd_data1 + s1_pkt.imm) & ~32'd1)
                         : (s1_pkt.pc + s1_pkt.imm);
    act_taken  = s1_pkt.jump ? 1'b1 : cond_taken;
    mispredict = (act_taken != s1_pkt.pred_taken) || is_jalr;
    redirect   = act_taken ? target : fall_pc;
  end

  // A mispredict currently leaving S2 means the S1 entry is wrong-path
  assign s1_resolve = s1_valid && !Predict_Result;

  // S2: register the resolved outcome; outputs stay zero when nothing resolves
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      BR_Done        <= 1'b0;
      BR_Phy         <= '0;
      BR_wr_en       <= 1'b0;
      BR_wr_data     <= '0;
      BR_inst_num    <= '0;
      Predict_Result <= 1'b0;
      Redirect_PC    <= '0;
      btb_upd_valid  <= 1'b0;
      btb_upd_PC     <= '0;
      btb_upd_target <= '0;
      btb_upd_taken  <= 1'b0;
    end else if (flush || !s1_resolve) begin
      BR_Done        <= 1'b0;
      BR_Phy         <= '0;
      BR_wr_en       <= 1'b0;
      BR_wr_data     <= '0;
      BR_inst_num    <= '0;
      Predict_Result <= 1'b0;
      Redirect_PC    <= '0;
      btb_upd_valid  <= 1'b0;
      btb_upd_PC     <= '0;
      btb_upd_target <= '0;
      btb_upd_taken  <= 1'b0;
    end else begin
      BR_Done        <= 1'b1;
      BR_Phy         <= s1_pkt.jump ? s1_pkt.phy : 8'd0;
      BR_wr_en       <= s1_pkt.jump && (s1_pkt.phy != 8'd0);
      BR_wr_data     <= fall_pc;
      BR_inst_num    <= s1_pkt.inst_num;
      Predict_Result <= mispredict;
      Redirect_PC    <= mispredict ? redirect : 32'd0;
      btb_upd_valid  <= 1'b1;
      btb_upd_PC     <= s1_pkt.pc;
      btb_upd_target <= target;
      btb_upd_taken  <= act_taken;
    end
  end

`ifdef BR_STATS_EN
  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_count         <= '0;
      mispredict_count <= '0;
    end else begin
      if (BR_Done && (br_count != 32'hFFFF_FFFF))
        br_count <= br_count + 32'd1;
      if (Predict_Result && (mispredict_count != 32'hFFFF_FFFF))
        mispredict_count <= mispredict_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_exec_unit.sv
// Testbench for branch_exec_unit: table of single-issue vectors plus
// hand-written pipeline sequences (squash, flush, reset). Expected results
// are queued when an issue is driven and compared when BR_Done appears.
// Define BR_STATS_EN to also check the statistics counters.
module tb_branch_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        RS_BR_Branch, RS_BR_Jump, RS_BR_Hit, RS_BR_taken;
  logic [7:0]  RS_BR_Phy;
  logic [31:0] RS_BR_inst_num;
  logic [2:0]  RS_BR_funct3;
  logic [31:0] immediate_BR, PC_BR;
  logic [7:0]  Operand1_BR_phy, Operand2_BR_phy;
  logic [7:0]  rf_rd_addr1, rf_rd_addr2;
  logic [31:0] rf_rd_data1, rf_rd_data2;
  logic        exception_sig, mret_sig;
  logic        BR_Done;
  logic [7:0]  BR_Phy;
  logic        BR_wr_en;
  logic [31:0] BR_wr_data, BR_inst_num;
  logic        Predict_Result;
  logic [31:0] Redirect_PC;
  logic        btb_upd_valid;
  logic [31:0] btb_upd_PC, btb_upd_target;
  logic        btb_upd_taken;
`ifdef BR_STATS_EN
  logic [31:0] br_count, mispredict_count;
`endif

  logic [31:0] rf_mem [256];
  assign rf_rd_data1 = rf_mem[rf_rd_addr1];
  assign rf_rd_data2 = rf_mem[rf_rd_addr2];

  branch_exec_unit dut (
    .clk(clk), .reset(reset),
    .RS_BR_Branch(RS_BR_Branch), .RS_BR_Jump(RS_BR_Jump),
    .RS_BR_Hit(RS_BR_Hit), .RS_BR_taken(RS_BR_taken),
    .RS_BR_Phy(RS_BR_Phy), .RS_BR_inst_num(RS_BR_inst_num),
    .RS_BR_funct3(RS_BR_funct3), .immediate_BR(immediate_BR), .PC_BR(PC_BR),
    .Operand1_BR_phy(Operand1_BR_phy), .Operand2_BR_phy(Operand2_BR_phy),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .exception_sig(exception_sig), .mret_sig(mret_sig),
    .BR_Done(BR_Done), .BR_Phy(BR_Phy), .BR_wr_en(BR_wr_en),
    .BR_wr_data(BR_wr_data), .BR_inst_num(BR_inst_num),
    .Predict_Result(Predict_Result), .Redirect_PC(Redirect_PC),
    .btb_upd_valid(btb_upd_valid), .btb_upd_PC(btb_upd_PC),
    .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken)
`ifdef BR_STATS_EN
    , .br_count(br_count), .mispredict_count(mispredict_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        br, jp, hit, tk;
    logic [2:0]  f3;
    logic [7:0]  phy, op1, op2;
    logic [31:0] pc, imm, d1, d2;
    logic        e_tk;
    logic [31:0] e_tgt;
    logic        e_mp;
    logic [31:0] e_rd;
    logic        e_we;
    logic [7:0]  e_phy;
  } vec_t;

  typedef struct packed {
    logic [31:0] inst_num;
    logic [7:0]  phy;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        predict;
    logic [31:0] redirect;
    logic        btb_valid;
    logic [31:0] btb_pc;
    logic [31:0] btb_target;
    logic        btb_taken;
  } exp_t;

  exp_t exp_q[$];
  int   due_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[15];
  exp_t got, want;
  int   due;
  logic [205:0] idle_bits;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mkvec(
    input logic br, input logic jp, input logic hit, input logic tk,
    input logic [2:0] f3, input logic [7:0] phy, input logic [7:0] op1,
    input logic [7:0] op2, input logic [31:0] pc, input logic [31:0] imm,
    input logic [31:0] d1, input logic [31:0] d2, input logic e_tk,
    input logic [31:0] e_tgt, input logic e_mp, input logic [31:0] e_rd,
    input logic e_we, input logic [7:0] e_phy);
    vec_t v;
    v.br = br; v.jp = jp; v.hit = hit; v.tk = tk; v.f3 = f3; v.phy = phy;
    v.op1 = op1; v.op2 = op2; v.pc = pc; v.imm = imm; v.d1 = d1; v.d2 = d2;
    v.e_tk = e_tk; v.e_tgt = e_tgt; v.e_mp = e_mp; v.e_rd = e_rd;
    v.e_we = e_we; v.e_phy = e_phy;
    return v;
  endfunction

  // Drive one issue on the cycle after the next edge; optionally queue its result
  task automatic apply_stimulus(input vec_t v, input logic [31:0] inum, input bit expect_done);
    exp_t e;
    @(posedge clk); #1;
    RS_BR_Branch = v.br; RS_BR_Jump = v.jp; RS_BR_Hit = v.hit; RS_BR_taken = v.tk;
    RS_BR_Phy = v.phy; RS_BR_inst_num = inum; RS_BR_funct3 = v.f3;
    immediate_BR = v.imm; PC_BR = v.pc;
    Operand1_BR_phy = v.op1; Operand2_BR_phy = v.op2;
    exception_sig = 1'b0; mret_sig = 1'b0;
    rf_mem[v.op1] = v.d1;
    rf_mem[v.op2] = v.d2;
    if (expect_done) begin
      e.inst_num = inum; e.phy = v.e_phy; e.wr_en = v.e_we;
      e.wr_data = v.pc + 32'd4; e.predict = v.e_mp; e.redirect = v.e_rd;
      e.btb_valid = 1'b1; e.btb_pc = v.pc; e.btb_target = v.e_tgt;
      e.btb_taken = v.e_tk;
      exp_q.push_back(e);
      due_q.push_back(cyc + 2);
    end
  endtask

  // Drive an all-zero bubble and release any flush request
  task automatic bubble();
    @(posedge clk); #1;
    RS_BR_Branch = 0; RS_BR_Jump = 0; RS_BR_Hit = 0; RS_BR_taken = 0;
    RS_BR_Phy = 0; RS_BR_inst_num = 0; RS_BR_funct3 = 0;
    immediate_BR = 0; PC_BR = 0; Operand1_BR_phy = 0; Operand2_BR_phy = 0;
    exception_sig = 0; mret_sig = 0;
  endtask

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  // Scoreboard: every resolving cycle pops a result, every other cycle must be all-zero
  always @(negedge clk) begin
    idle_bits = {BR_Done, BR_Phy, BR_wr_en, BR_wr_data, BR_inst_num, Predict_Result,
                 Redirect_PC, btb_upd_valid, btb_upd_PC, btb_upd_target, btb_upd_taken};
    if (BR_Done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_done: got BR_Done inst_num=%h, required no BR_Done", BR_inst_num);
      end else begin
        want = exp_q.pop_front();
        due  = due_q.pop_front();
        got.inst_num = BR_inst_num; got.phy = BR_Phy; got.wr_en = BR_wr_en;
        got.wr_data = BR_wr_data; got.predict = Predict_Result;
        got.redirect = Redirect_PC; got.btb_valid = btb_upd_valid;
        got.btb_pc = btb_upd_PC; got.btb_target = btb_upd_target;
        got.btb_taken = btb_upd_taken;
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL resolve_%0h: got %h, required %h", want.inst_num, got, want);
        end
        checks++;
        if (cyc != due) begin
          errors++;
          $display("[TB] FAIL latency_%0h: got cycle %0d, required %0d", want.inst_num, cyc, due);
        end
      end
    end else begin
      checks++;
      if (idle_bits !== '0) begin
        errors++;
        $display("[TB] FAIL idle_zero: got %h, required 0", idle_bits);
      end
    end
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) rf_mem[i] = 32'd0;
    RS_BR_Branch = 0; RS_BR_Jump = 0; RS_BR_Hit = 0; RS_BR_taken = 0;
    RS_BR_Phy = 0; RS_BR_inst_num = 0; RS_BR_funct3 = 0;
    immediate_BR = 0; PC_BR = 0; Operand1_BR_phy = 0; Operand2_BR_phy = 0;
    exception_sig = 0; mret_sig = 0;
    reset = 1'b1;
    #2 reset = 1'b0;

    //            br jp hit tk f3      phy    op1    op2    pc            imm           d1            d2    e_tk e_tgt        e_mp e_rd         we phy
    vecs[0]  = mkvec(1,0,1,1,3'b000,8'h30,8'h01,8'h02,32'h100,     32'h20,      32'd5,       32'd5, 1,32'h120,     0,32'h0,     0,8'h00);
    vecs[1]  = mkvec(1,0,0,0,3'b100,8'h31,8'h03,8'h04,32'h200,     32'h40,      32'hFFFFFFFF,32'd1, 1,32'h240,     1,32'h240,   0,8'h00);
    vecs[2]  = mkvec(1,0,0,0,3'b110,8'h32,8'h05,8'h06,32'h300,     32'h40,      32'hFFFFFFFF,32'd1, 0,32'h340,     0,32'h0,     0,8'h00);
    vecs[3]  = mkvec(0,1,1,1,3'b000,8'h07,8'h12,8'h08,32'h400,     32'h4,       32'h2001,    32'd0, 1,32'h2004,    1,32'h2004,  1,8'h07);
    vecs[4]  = mkvec(0,1,1,1,3'b000,8'h05,8'hFF,8'h09,32'h500,     32'h100,     32'd0,       32'd0, 1,32'h600,     0,32'h0,     1,8'h05);
    vecs[5]  = mkvec(0,1,0,0,3'b000,8'h00,8'hFF,8'h0A,32'h600,     32'hFFFFFFF8,32'd0,       32'd0, 1,32'h5F8,     1,32'h5F8,   0,8'h00);
    vecs[6]  = mkvec(1,0,1,1,3'b001,8'h33,8'h0B,8'h0C,32'h700,     32'h10,      32'd3,       32'd3, 0,32'h710,     1,32'h704,   0,8'h00);
    vecs[7]  = mkvec(1,0,0,0,3'b101,8'h34,8'h0D,8'h0E,32'h800,     32'h20,      32'h80000000,32'd1, 0,32'h820,     0,32'h0,     0,8'h00);
    vecs[8]  = mkvec(1,0,1,0,3'b111,8'h35,8'h0F,8'h10,32'h900,     32'h20,      32'h80000000,32'd1, 1,32'h920,     1,32'h920,   0,8'h00);
    vecs[9]  = mkvec(1,0,1,1,3'b010,8'h36,8'h11,8'h13,32'hA00,     32'h8,       32'd7,       32'd7, 0,32'hA08,     1,32'hA04,   0,8'h00);
    vecs[10] = mkvec(1,0,1,1,3'b000,8'h37,8'h14,8'h15,32'hFFFFFFF0,32'h20,      32'd9,       32'd9, 1,32'h10,      0,32'h0,     0,8'h00);
    vecs[11] = mkvec(1,0,0,1,3'b000,8'h38,8'h16,8'h17,32'hB00,     32'h40,      32'd1,       32'd2, 0,32'hB40,     0,32'h0,     0,8'h00);
    vecs[12] = mkvec(1,0,1,1,3'b001,8'h39,8'h18,8'h19,32'hFFFFFFFC,32'h10,      32'd4,       32'd4, 0,32'hC,       1,32'h0,     0,8'h00);
    vecs[13] = mkvec(0,1,0,0,3'b000,8'h00,8'h1A,8'h1B,32'hE00,     32'hFFFFFFFF,32'h3000,    32'd0, 1,32'h2FFE,    1,32'h2FFE,  0,8'h00);
    vecs[14] = mkvec(1,0,1,1,3'b000,8'h3A,8'h40,8'h41,32'hC00,     32'h10,      32'd9,       32'd9, 1,32'hC10,     0,32'h0,     0,8'h00);

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_outputs", {BR_Done, Predict_Result, btb_upd_valid, BR_wr_en, Redirect_PC}, 64'd0);
    check_output("reset_rf_addr", {rf_rd_addr1, rf_rd_addr2}, 64'd0);
    reset = 1'b1;

    // Single issues separated by a bubble
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i], 32'h100 + i, 1'b1);
      bubble();
`ifdef BR_STATS_EN
      if (i == 2) begin
        repeat (3) @(posedge clk);
        #1;
        check_output("br_count", br_count, 64'd3);
        check_output("mispredict_count", mispredict_count, 64'd1);
      end
`endif
    end

    // Back-to-back correctly predicted branches, one per cycle
    for (int i = 0; i < 3; i++) begin
      vec_t v;
      v = vecs[14];
      v.op1 = 8'h50 + 8'(2 * i); v.op2 = 8'h51 + 8'(2 * i);
      v.pc = 32'hD00 + 32'(16 * i); v.e_tgt = v.pc + 32'h10;
      apply_stimulus(v, 32'h200 + i, 1'b1);
    end
    bubble();
    bubble();

    // Mispredict in S2 squashes the next issue but not the one after
    begin
      vec_t x, y;
      x = vecs[1]; x.op1 = 8'h60; x.op2 = 8'h61;
      y = vecs[14]; y.op1 = 8'h62; y.op2 = 8'h63;
      apply_stimulus(x, 32'h300, 1'b1);
      apply_stimulus(y, 32'h301, 1'b0);
      y.op1 = 8'h64; y.op2 = 8'h65;
      apply_stimulus(y, 32'h302, 1'b1);
      bubble();
      bubble();
    end

    // Exception on the cycle after the first of two back-to-back issues
    apply_stimulus(vecs[14], 32'h400, 1'b0);
    vecs[14].op1 = 8'h66; vecs[14].op2 = 8'h67;
    apply_stimulus(vecs[14], 32'h401, 1'b0);
    exception_sig = 1'b1;
    bubble();
    bubble();
    bubble();

    // mret while an issue sits in S1
    apply_stimulus(vecs[0], 32'h410, 1'b0);
    bubble();
    mret_sig = 1'b1;
    bubble();
    bubble();
    bubble();

    // Reset dropped while one entry is resolving and another is in S1
    apply_stimulus(vecs[0], 32'h500, 1'b0);
    apply_stimulus(vecs[2], 32'h501, 1'b0);
    @(posedge clk); #1;
    check_output("pre_reset_done", {63'd0, BR_Done}, 64'd1);
    #1 reset = 1'b0;
    #1;
    check_output("reset_async_done", {63'd0, BR_Done}, 64'd0);
    check_output("reset_async_outs", {Predict_Result, BR_inst_num, btb_upd_PC}, 64'd0);
    apply_stimulus(vecs[3], 32'h502, 1'b0);
    bubble();
    #2 reset = 1'b1;
    repeat (4) bubble();

    // Recovery after reset
    apply_stimulus(vecs[3], 32'h600, 1'b1);
    repeat (5) bubble();

    check_output("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
